// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the PISO shift register.
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit index, cleared on accept and saturating at max.
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] cnt,
  output logic          at_max
);
  logic [CW-1:0] cnt_q;
  assign cnt    = cnt_q;
  assign at_max = cnt_q == max;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (inc && !at_max) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/piso_shift_register.sv
// piso_shift_register: valid/ready loaded word sent one bit per clk with s_valid/s_last framing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  state_t           state_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             s_out_q, s_valid_q, s_last_q;
  logic             head, next_bit_d, accept, at_max;
  logic [CW-1:0]    cnt;
  assign load_ready = (state_q == IDLE) || (state_q == SHIFT && at_max);
  assign accept     = load_valid && load_ready;
  assign busy       = state_q == SHIFT;
  assign s_out      = s_out_q;
  assign s_valid    = s_valid_q;
  assign s_last     = s_last_q;
  assign head       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_d    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
`ifdef PISO_PARITY_EN
  logic par_q;
  assign next_bit_d = (cnt == CW'(WIDTH - 1)) ? par_q : head;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else if (accept) par_q <= ^p_in;
  end
`else
  assign next_bit_d = head;
`endif
  piso_bit_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .inc   (state_q == SHIFT && !at_max),
    .max   (CW'(NBITS - 1)),
    .cnt   (cnt),
    .at_max(at_max)
  );
  // The first bit is registered at accept, so shreg_q holds only the bits still to send.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      s_out_q   <= IDLE_LEVEL;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end else if (accept) begin
      state_q   <= SHIFT;
      shreg_q   <= MSB_FIRST ? p_in << 1 : p_in >> 1;
      s_out_q   <= MSB_FIRST ? p_in[WIDTH-1] : p_in[0];
      s_valid_q <= 1'b1;
      s_last_q  <= 1'b0;
    end else if (state_q == SHIFT && !at_max) begin
      shreg_q   <= shreg_d;
      s_out_q   <= next_bit_d;
      s_last_q  <= cnt == CW'(NBITS - 2);
    end else if (state_q == SHIFT) begin
      state_q   <= IDLE;
      s_out_q   <= IDLE_LEVEL;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: LSB-first and MSB-first instances checked against a bit-queue model.
module tb_piso_shift_register;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] pa = '0, pm = '0;
  logic lva = 1'b0, lvm = 1'b0;
  logic ra, oa, va, la, ba, rm, om, vm, lm, bm;
  int vectors = 0, fails = 0;
  logic [1:0] qa[$], qm[$];

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .p_in(pa), .load_valid(lva), .load_ready(ra),
    .s_out(oa), .s_valid(va), .s_last(la), .busy(ba));
  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .p_in(pm), .load_valid(lvm), .load_ready(rm),
    .s_out(om), .s_valid(vm), .s_last(lm), .busy(bm));

  // Model: each queue entry is {last, bit} for a bit still to be shown; the head is on the wire.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa.delete();
      qm.delete();
    end else begin
      if (lva && qa.size() <= 1) begin
        if (qa.size() > 0) void'(qa.pop_front());
        for (int i = 0; i < NB; i++) qa.push_back({i == NB - 1, i < W ? pa[i] : ^pa});
      end else if (qa.size() > 0) void'(qa.pop_front());
      if (lvm && qm.size() <= 1) begin
        if (qm.size() > 0) void'(qm.pop_front());
        for (int i = 0; i < NB; i++) qm.push_back({i == NB - 1, i < W ? pm[(W - 1 - i) % W] : ^pm});
      end else if (qm.size() > 0) void'(qm.pop_front());
    end
  end

  function automatic logic [4:0] exp_a();
    return qa.size() == 0 ? 5'b00001 : {qa[0][0], 1'b1, qa[0][1], 1'b1, qa.size() == 1};
  endfunction
  function automatic logic [4:0] exp_m();
    return qm.size() == 0 ? 5'b00001 : {qm[0][0], 1'b1, qm[0][1], 1'b1, qm.size() == 1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; lva = 1'b0; lvm = 1'b0;
    repeat (3) cyc();
    vectors++;
    if ({oa, va, la, ba, ra} !== 5'b00001) begin
      fails++; $display("FAIL reset_a: got %b expected 00001", {oa, va, la, ba, ra});
    end
    vectors++;
    if ({om, vm, lm, bm, rm} !== 5'b00001) begin
      fails++; $display("FAIL reset_m: got %b expected 00001", {om, vm, lm, bm, rm});
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_lsb_frame();
    logic [W-1:0] got = '0;
    int nv = 0;
    pa = 4'b1011; lva = 1'b1;
    for (int i = 0; i < NB + 3; i++) begin
      cyc();
      if (i == 0) begin lva = 1'b0; pa = ~pa; end
      vectors++;
      if ({oa, va, la, ba, ra} !== exp_a()) begin
        fails++; $display("FAIL lsb_frame cyc%0d: got %b expected %b", i, {oa, va, la, ba, ra}, exp_a());
      end
      if (va) begin
        if (nv < W) got = {oa, got[W-1:1]};
        nv++;
      end
    end
    vectors++;
    if (got !== 4'b1011 || nv != NB) begin
      fails++; $display("FAIL lsb_frame_word: got %b/%0d valid expected 1011/%0d", got, nv, NB);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[2];
    logic [2*W-1:0] got = '0;
    int idx = 0, nv = 0, nl = 0, first = -1, last = -1;
    bit acc;
    w[0] = 4'b1011; w[1] = 4'b0110;
    pa = w[0]; lva = 1'b1;
    for (int i = 0; i < 2 * NB + 3; i++) begin
      acc = lva && qa.size() <= 1;
      cyc();
      if (acc) begin
        idx++;
        if (idx == 2) lva = 1'b0; else pa = w[idx];
      end
      vectors++;
      if ({oa, va, la, ba, ra} !== exp_a()) begin
        fails++; $display("FAIL back_to_back cyc%0d: got %b expected %b", i, {oa, va, la, ba, ra}, exp_a());
      end
      if (va) begin
        if (nv % NB < W) got = {got[2*W-2:0], oa};
        if (la) nl++;
        if (first < 0) first = i;
        last = i;
        nv++;
      end
    end
    vectors++;
    if (got !== 8'b11010110 || nv != 2 * NB || nl != 2 || last - first + 1 != nv) begin
      fails++;
      $display("FAIL back_to_back_stream: got %b valid=%0d last=%0d span=%0d expected 11010110 valid=%0d last=2",
               got, nv, nl, last - first + 1, 2 * NB);
    end
  endtask

  task automatic test_busy_ignore();
    logic [2*W-1:0] got = '0;
    int nv = 0;
    bit acc;
    pa = 4'b0001; lva = 1'b1;
    for (int i = 0; i < 2 * NB + 3; i++) begin
      acc = lva && qa.size() <= 1;
      cyc();
      vectors++;
      if ({oa, va, la, ba, ra} !== exp_a()) begin
        fails++; $display("FAIL busy_ignore cyc%0d: got %b expected %b", i, {oa, va, la, ba, ra}, exp_a());
      end
      if (i == 0) lva = 1'b0;
      if (i == 1) begin lva = 1'b1; pa = 4'b1111; end
      if (acc && i > 0) lva = 1'b0;
      if (va) begin
        if (nv % NB < W) got = {got[2*W-2:0], oa};
        nv++;
      end
    end
    vectors++;
    if (got !== 8'b10001111 || nv != 2 * NB) begin
      fails++; $display("FAIL busy_ignore_stream: got %b/%0d expected 10001111/%0d", got, nv, 2 * NB);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] got = '0;
    int nv = 0;
    pa = 4'b1011; lva = 1'b1;
    cyc();
    lva = 1'b0;
    cyc();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({oa, va, la, ba, ra} !== 5'b00001) begin
      fails++; $display("FAIL reset_mid_async: got %b expected 00001", {oa, va, la, ba, ra});
    end
    cyc();
    reset = 1'b1;
    cyc();
    pa = 4'b0101; lva = 1'b1;
    for (int i = 0; i < NB + 2; i++) begin
      cyc();
      if (i == 0) lva = 1'b0;
      vectors++;
      if ({oa, va, la, ba, ra} !== exp_a()) begin
        fails++; $display("FAIL reset_mid_refill cyc%0d: got %b expected %b", i, {oa, va, la, ba, ra}, exp_a());
      end
      if (va) begin
        if (nv < W) got = {oa, got[W-1:1]};
        nv++;
      end
    end
    vectors++;
    if (got !== 4'b0101 || nv != NB) begin
      fails++; $display("FAIL reset_mid_word: got %b/%0d expected 0101/%0d", got, nv, NB);
    end
  endtask

  task automatic test_msb_frame();
    logic [W-1:0] got = '0;
    logic par = 1'b0;
    int nv = 0;
    pm = 4'b1011; lvm = 1'b1;
    for (int i = 0; i < NB + 3; i++) begin
      cyc();
      if (i == 0) begin lvm = 1'b0; pm = W'($urandom); end
      vectors++;
      if ({om, vm, lm, bm, rm} !== exp_m()) begin
        fails++; $display("FAIL msb_frame cyc%0d: got %b expected %b", i, {om, vm, lm, bm, rm}, exp_m());
      end
      if (vm) begin
        if (nv < W) got = {got[W-2:0], om}; else par = om;
        nv++;
      end
    end
    vectors++;
    if (got !== 4'b1011 || nv != NB) begin
      fails++; $display("FAIL msb_frame_word: got %b/%0d expected 1011/%0d", got, nv, NB);
    end
`ifdef PISO_PARITY_EN
    vectors++;
    if (par !== 1'b1) begin
      fails++; $display("FAIL msb_parity: got %b expected 1", par);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      lva = 1'($urandom_range(0, 1));
      lvm = 1'($urandom_range(0, 1));
      pa  = W'($urandom);
      pm  = W'($urandom);
      reset = ($urandom_range(0, 49) != 0);
      cyc();
      vectors++;
      if ({oa, va, la, ba, ra} !== exp_a()) begin
        fails++; $display("FAIL random_a cyc%0d: got %b expected %b", i, {oa, va, la, ba, ra}, exp_a());
      end
      vectors++;
      if ({om, vm, lm, bm, rm} !== exp_m()) begin
        fails++; $display("FAIL random_m cyc%0d: got %b expected %b", i, {om, vm, lm, bm, rm}, exp_m());
      end
    end
    reset = 1'b1; lva = 1'b0; lvm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_msb_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
